// File: rtl/rom_arbiter.sv
// rom_arbiter
// Shares the single-ported 1K x 16 program ROM between the F100-L core's
// instruction fetch (port 0) and operand/data reads (port 1). An access is
// granted in IDLE, the ROM address is held for WAIT_STATES extra cycles in
// READ, the word is captured into data_out and the owner's ack pulses for
// exactly one cycle in DONE.
// Optional build macro: ROM_ARB_ROUND_ROBIN_EN -- on a tie the port that did
// not win the previous grant wins; otherwise port 0 always wins ties.
module rom_arbiter #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_0,
   input  logic [9:0]  addr_0,
   output logic        ack_0,
   input  logic        req_1,
   input  logic [9:0]  addr_1,
   output logic        ack_1,
   output logic [15:0] data_out,
   output logic        grant,
   output logic        busy,
   output logic [9:0]  rom_address,
   input  logic [15:0] rom_data_in
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   // Wait-state count loaded at grant; legal range is 0-7.
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

   state_t      state_q, state_d;
   logic [2:0]  wait_q,  wait_d;
   logic [9:0]  addr_q,  addr_d;
   logic [15:0] data_q,  data_d;
   logic        grant_q, grant_d;
   logic        ack_0_q, ack_0_d;
   logic        ack_1_q, ack_1_d;

   logic        any_req;
   logic        winner;

   assign any_req = req_0 | req_1;

`ifdef ROM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // Winner select: a sole requester wins, a tie goes to the port that lost last time.
   always_comb begin
      winner = req_1;
      if (req_0 && req_1) begin
         winner = ~last_q;
      end
   end

   // History only moves when a grant is actually issued.
   assign last_d = (state_q == IDLE && any_req) ? winner : last_q;

   // Last-winner register; reset value 1 lets port 0 take the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: port 0 wins whenever it is requesting.
   assign winner = ~req_0;
`endif

   // Sequencer next-state: grant in IDLE, count wait states in READ, ack in DONE.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      data_d  = data_q;
      grant_d = grant_q;
      ack_0_d = 1'b0;
      ack_1_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               // The address is latched here; later addr_x changes are ignored.
               addr_d  = winner ? addr_1 : addr_0;
               grant_d = winner;
               wait_d  = WAIT_INIT;
               state_d = READ;
            end
         end

         READ: begin
            if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end else begin
               data_d  = rom_data_in;
               ack_0_d = ~grant_q;
               ack_1_d = grant_q;
               state_d = DONE;
            end
         end

         DONE: begin
            // Acks drop by default; IDLE re-samples the requests next edge.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers; reset aborts any access in flight without an ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wait_q  <= 3'd0;
         addr_q  <= 10'd0;
         data_q  <= 16'd0;
         grant_q <= 1'b0;
         ack_0_q <= 1'b0;
         ack_1_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         ack_0_q <= ack_0_d;
         ack_1_q <= ack_1_d;
      end
   end

   assign ack_0       = ack_0_q;
   assign ack_1       = ack_1_q;
   assign data_out    = data_q;
   assign grant       = grant_q;
   assign busy        = (state_q != IDLE);
   assign rom_address = addr_q;

endmodule
